fsm_seq_param: RTL and testbench
================================

# fsm_seq_param

Parametrised state sequencer, successor to the team's fixed 16-state ring FSM. It steps a registered state index through `N_STATES` positions. Step direction, end-of-sequence mode (wrap, one-shot, ping-pong), hold-vs-restart on `start` deassertion and parallel load are all selectable at run time. It sits beside the datapath as its phase/step generator, and `wrap` and `done` feed downstream control.

## Interface
Parameters:
- `N_STATES`, 16, number of sequence positions; legal range 2..256.
- `STATE_W`, 5, width of `state`/`load_val`; must satisfy 2^STATE_W >= N_STATES.
- `DWELL_W`, 4, width of `dwell` (used only with `FSM_SEQ_DWELL_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  run enable; sequencer advances only while high.
- `hold`  in  1  behaviour when `start` low: 0 = return to state 0, 1 = freeze state.
- `dir`  in  1  0 = count up, 1 = count down (wrap/one-shot modes).
- `mode`  in  2  00 wrap, 01 one-shot, 10 ping-pong, 11 treated as wrap.
- `load`  in  1  synchronous parallel load strobe.
- `load_val`  in  STATE_W  value loaded when `load` high.
- `dwell`  in  DWELL_W  extra cycles spent in each state (present only with macro).
- `state`  out  STATE_W  current state index.
- `wrap`  out  1  one-cycle pulse on sequence end crossing.
- `done`  out  1  one-shot completion flag, sticky.
- `busy`  out  1  high while `start` high and not `done`.

## Operation
- Reset (`rst_n` low at clk edge): `state`=0, `wrap`=0, `done`=0, `busy`=0, ping-pong direction flag=up, dwell counter=0.
- Priority per edge: reset > `load` > `start` low > advance.
- `load`: `state`←`load_val`; out-of-range values (>= N_STATES) load 0. `done` clears and the dwell counter clears. Ping-pong flag unchanged.
- `start` low: `hold`=0 gives `state`←0, `done`←0, ping-pong flag←up. `hold`=1 keeps `state`, `done` and the flag. In both cases the dwell counter clears.
- Advance (`start` high, dwell expired):
  - Wrap: up steps N−1→0 and down steps 0→N−1; `wrap` pulses.
  - One-shot: stepping stops at the end state (N−1 up, 0 down), where `done`←1 and `wrap` pulses once. The state then holds until `start` low with `hold`=0, or `load`.
  - Ping-pong: `dir` is ignored. The internal flag reverses on reaching N−1 or 0, so the sequence runs 0,1,…,N−1,N−2,…,0,1…. `wrap` pulses on arrival at 0 only.
- `state` >= N_STATES (illegal, e.g. upset) forces `state`←0 on the next edge with no `wrap`.
- `dir`/`mode` changes take effect on the next advance; no state is lost.

## Timing
- All outputs are registered. `state` changes one edge after the qualifying inputs are sampled.
- `wrap` is high in exactly the cycle `state` first shows the end-crossing value; it is 0 otherwise.
- Without dwell: one advance per cycle while `start` is high.
- `busy` = registered (`start` & ~`done`), updated every edge.

## Configuration
- `FSM_SEQ_DWELL_EN` defined:
  - The `dwell` port exists. Each state is held for `dwell`+1 advance-eligible cycles before stepping.
  - `dwell` is sampled when the counter restarts, i.e. on entry to each state.
  - `dwell`=0 gives the same behaviour as the macro undefined.
- Undefined: no `dwell` port and no counter; advance every cycle.

## Structure
- Package `fsm_seq_pkg` holds:
  - `seq_mode_t` enum (MODE_WRAP, MODE_ONESHOT, MODE_PINGPONG).
  - Direction constants DIR_UP/DIR_DOWN.
  - A helper function computing the end state from direction.
- Sub-module `fsm_dwell_cnt` (DWELL_W-bit down-counter with clear, load and expire output) is instantiated only under `FSM_SEQ_DWELL_EN`.

## Test plan
- Reset: hold `rst_n` low for 2 cycles with `start`=1 → `state`=0, `wrap`=0, `done`=0, `busy`=0. Release with N=16, mode=00, dir=0 → `state` 1..15,0 on consecutive edges; `wrap`=1 only with `state`=0.
- Down/one-shot: N=10, mode=01, dir=1, load 3 then `start`=1 → states 2,1,0; `done`=1 and one `wrap` pulse at 0; `state` stays 0 for 5 more cycles; `busy`=0.
- Ping-pong: N=4, mode=10 → sequence 0,1,2,3,2,1,0,1; `wrap` pulses only on the returns to 0.
- Hold: at `state`=7, drop `start` with `hold`=1 for 3 cycles → `state` stays 7, then resumes 8. Repeat with `hold`=0 → `state`=0 next edge.
- Load edge cases: `load`=1 with `load_val`=20 and N=16 → `state`=0. Assert `load` together with `start` low and `hold`=0 → load wins. Apply `rst_n` low mid-sequence → all outputs reset next edge.
- Dwell (macro on): `dwell`=2, N=4, wrap mode → each state is held 3 cycles; 0→1 transition at cycle 3; `wrap` at cycle 12.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared types and helpers for the parametrised state sequencer.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PINGPONG = 2'b10
  } seq_mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Terminal position of a sweep in the given direction.
  function automatic int unsigned seq_end_state(input logic dir, input int unsigned n_states);
    return (dir == DIR_DOWN) ? 0 : n_states - 1;
  endfunction

endpackage

// File: rtl/fsm_dwell_cnt.sv
// Per-state dwell down-counter: reloads from i_dwell on entry to each state and
// flags expiry once the state has been held i_dwell+1 enabled cycles.
module fsm_dwell_cnt #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic               o_expire
);

  logic [DWELL_W-1:0] r_cnt;
  logic               r_reload;
  logic [DWELL_W-1:0] w_rem;

  // On the first eligible cycle of a state the live dwell value is the count.
  assign w_rem    = r_reload ? i_dwell : r_cnt;
  assign o_expire = (w_rem == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt    <= '0;
      r_reload <= 1'b1;
    end else if (i_en) begin
      if (o_expire) begin
        r_reload <= 1'b1;
      end else begin
        r_cnt    <= w_rem - DWELL_W'(1);
        r_reload <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fsm_seq_param.sv
// Run-time configurable state sequencer (wrap / one-shot / ping-pong).
// Optional per-state dwell enabled by defining FSM_SEQ_DWELL_EN.
module fsm_seq_param #(
  parameter int N_STATES = 16,
  parameter int STATE_W  = 5,
  parameter int DWELL_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [STATE_W-1:0] load_val,
`ifdef FSM_SEQ_DWELL_EN
  input  logic [DWELL_W-1:0] dwell,
`endif
  output logic [STATE_W-1:0] state,
  output logic               wrap,
  output logic               done,
  output logic               busy
);
  import fsm_seq_pkg::*;

  localparam logic [STATE_W-1:0] LAST   = STATE_W'(N_STATES - 1);
  localparam logic [STATE_W:0]   NS_EXT = (STATE_W + 1)'(N_STATES);

  if (N_STATES < 2 || N_STATES > 256 || (2 ** STATE_W) < N_STATES || DWELL_W < 1) begin : g_bad_cfg
    $error("fsm_seq_param: illegal parameter combination");
  end

  logic [STATE_W-1:0] r_state, w_state_nxt, w_end;
  logic               r_wrap, w_wrap_nxt;
  logic               r_done, w_done_nxt;
  logic               r_busy;
  logic               r_pp_dn, w_pp_dn_nxt;
  logic               w_legal, w_load_ok, w_adv_ok, w_expire;

  assign w_legal   = ({1'b0, r_state} < NS_EXT);
  assign w_load_ok = ({1'b0, load_val} < NS_EXT);
  assign w_end     = STATE_W'(seq_end_state(dir, N_STATES));
  assign w_adv_ok  = ~load & w_legal & start;

`ifdef FSM_SEQ_DWELL_EN
  fsm_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (~w_adv_ok),
    .i_en     (w_adv_ok),
    .i_dwell  (dwell),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = r_done;
    w_pp_dn_nxt = r_pp_dn;
    if (load) begin
      w_state_nxt = w_load_ok ? load_val : '0;
      w_done_nxt  = 1'b0;
    end else if (!w_legal) begin
      w_state_nxt = '0;
    end else if (!start) begin
      if (!hold) begin
        w_state_nxt = '0;
        w_done_nxt  = 1'b0;
        w_pp_dn_nxt = 1'b0;
      end
    end else if (w_expire) begin
      case (mode)
        MODE_ONESHOT: begin
          // Once done the state is frozen even if dir changes afterwards.
          if (!r_done) begin
            if (r_state == w_end) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = (dir == DIR_DOWN) ? r_state - STATE_W'(1) : r_state + STATE_W'(1);
              if (w_state_nxt == w_end) begin
                w_done_nxt = 1'b1;
                w_wrap_nxt = 1'b1;
              end
            end
          end
        end
        MODE_PINGPONG: begin
          if (!r_pp_dn) begin
            if (r_state == LAST) begin
              w_state_nxt = LAST - STATE_W'(1);
              w_pp_dn_nxt = 1'b1;
            end else begin
              w_state_nxt = r_state + STATE_W'(1);
            end
          end else begin
            if (r_state == '0) begin
              w_state_nxt = STATE_W'(1);
              w_pp_dn_nxt = 1'b0;
            end else begin
              w_state_nxt = r_state - STATE_W'(1);
            end
          end
          w_wrap_nxt = (w_state_nxt == '0);
        end
        default: begin
          if (dir == DIR_DOWN) begin
            w_state_nxt = (r_state == '0) ? LAST : r_state - STATE_W'(1);
            w_wrap_nxt  = (r_state == '0);
          end else begin
            w_state_nxt = (r_state == LAST) ? '0 : r_state + STATE_W'(1);
            w_wrap_nxt  = (r_state == LAST);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_pp_dn <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= start & ~r_done;
      r_pp_dn <= w_pp_dn_nxt;
    end
  end

  assign state = r_state;
  assign wrap  = r_wrap;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule

// File: tb/tb_fsm_seq_param.sv
// Scoreboard bench for fsm_seq_param: three instances (N=16, 10, 4) share the
// stimulus; each vector names the instance whose outputs it predicts.
module tb_fsm_seq_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [4:0] load_val = 5'd0;
  logic [3:0] dwell = 4'd0;

  logic [4:0] st_a, st_b, st_c;
  logic       wr_a, wr_b, wr_c, dn_a, dn_b, dn_c, bz_a, bz_b, bz_c;

  always #5 clk = ~clk;

  fsm_seq_param #(.N_STATES(16), .STATE_W(5), .DWELL_W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
`ifdef FSM_SEQ_DWELL_EN
    .dwell(dwell),
`endif
    .state(st_a), .wrap(wr_a), .done(dn_a), .busy(bz_a));

  fsm_seq_param #(.N_STATES(10), .STATE_W(5), .DWELL_W(4)) u10 (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
`ifdef FSM_SEQ_DWELL_EN
    .dwell(dwell),
`endif
    .state(st_b), .wrap(wr_b), .done(dn_b), .busy(bz_b));

  fsm_seq_param #(.N_STATES(4), .STATE_W(5), .DWELL_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
`ifdef FSM_SEQ_DWELL_EN
    .dwell(dwell),
`endif
    .state(st_c), .wrap(wr_c), .done(dn_c), .busy(bz_c));

  typedef struct {
    int         sel;
    logic [4:0] st;
    logic       wr;
    logic       dn;
    logic       bz;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Drive one cycle of inputs at the falling edge and predict the outputs
  // that the following rising edge must produce.
  task automatic vec(input int sel, input logic rn, input logic st, input logic hd,
                     input logic dr, input logic [1:0] md, input logic ld,
                     input logic [4:0] lv, input logic [4:0] es, input logic ew,
                     input logic ed, input logic eb, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = rn; start = st; hold = hd; dir = dr; mode = md; load = ld; load_val = lv;
    e.sel = sel; e.st = es; e.wr = ew; e.dn = ed; e.bz = eb; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] a_st;
    logic       a_wr, a_dn, a_bz;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       begin a_st = st_a; a_wr = wr_a; a_dn = dn_a; a_bz = bz_a; end
          1:       begin a_st = st_b; a_wr = wr_b; a_dn = dn_b; a_bz = bz_b; end
          default: begin a_st = st_c; a_wr = wr_c; a_dn = dn_c; a_bz = bz_c; end
        endcase
        n_vec++;
        if (a_st !== e.st || a_wr !== e.wr || a_dn !== e.dn || a_bz !== e.bz) begin
          n_bad++;
          $display("FAIL %s (dut %0d): got state=%0d wrap=%b done=%b busy=%b, want state=%0d wrap=%b done=%b busy=%b",
                   e.nm, e.sel, a_st, a_wr, a_dn, a_bz, e.st, e.wr, e.dn, e.bz);
        end
      end
    end
  end

  initial begin : stimulus
    logic [4:0] pp[8];
    pp[0] = 5'd1; pp[1] = 5'd2; pp[2] = 5'd3; pp[3] = 5'd2;
    pp[4] = 5'd1; pp[5] = 5'd0; pp[6] = 5'd1; pp[7] = 5'd2;

    // Reset held with start high, then a full up-count wrap on N=16
    vec(0, 0, 1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 0, 0, "rst0");
    vec(0, 0, 1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 0, 0, "rst1");
    for (int k = 1; k <= 16; k++)
      vec(0, 1, 1, 0, 0, 2'b00, 0, 5'd0, 5'(k % 16), (k == 16), 0, 1, "wrap_up");

    // Down one-shot on N=10 from a loaded 3
    vec(1, 0, 0, 0, 1, 2'b01, 0, 5'd0, 5'd0, 0, 0, 0, "rst_b");
    vec(1, 1, 0, 0, 1, 2'b01, 1, 5'd3, 5'd3, 0, 0, 0, "os_ld3");
    vec(1, 1, 1, 0, 1, 2'b01, 0, 5'd0, 5'd2, 0, 0, 1, "os_2");
    vec(1, 1, 1, 0, 1, 2'b01, 0, 5'd0, 5'd1, 0, 0, 1, "os_1");
    vec(1, 1, 1, 0, 1, 2'b01, 0, 5'd0, 5'd0, 1, 1, 1, "os_end");
    for (int k = 0; k < 5; k++)
      vec(1, 1, 1, 0, 1, 2'b01, 0, 5'd0, 5'd0, 0, 1, 0, "os_stay");
    vec(1, 1, 1, 0, 1, 2'b01, 1, 5'd9, 5'd9, 0, 0, 0, "os_ld_clr");

    // Ping-pong on N=4, dir deliberately high to show it is ignored
    vec(2, 0, 0, 0, 1, 2'b10, 0, 5'd0, 5'd0, 0, 0, 0, "rst_c");
    for (int k = 0; k < 8; k++)
      vec(2, 1, 1, 0, 1, 2'b10, 0, 5'd0, pp[k], (k == 5), 0, 1, "pingpong");

    // Hold / restart on N=16
    vec(0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 0, 0, "rst_h");
    vec(0, 1, 1, 0, 0, 2'b00, 1, 5'd7, 5'd7, 0, 0, 1, "ld7");
    for (int k = 0; k < 3; k++)
      vec(0, 1, 0, 1, 0, 2'b00, 0, 5'd0, 5'd7, 0, 0, 0, "hold1");
    vec(0, 1, 1, 0, 0, 2'b00, 0, 5'd0, 5'd8, 0, 0, 1, "resume");
    vec(0, 1, 0, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 0, 0, "hold0");

    // Load edge cases, down wrap, mode 11 and mid-sequence reset on N=16
    vec(0, 1, 1, 0, 0, 2'b00, 1, 5'd20, 5'd0, 0, 0, 1, "ld_oor");
    vec(0, 1, 1, 0, 0, 2'b00, 0, 5'd0, 5'd1, 0, 0, 1, "adv1");
    vec(0, 1, 0, 0, 0, 2'b00, 1, 5'd5, 5'd5, 0, 0, 0, "ld_wins");
    vec(0, 1, 1, 0, 0, 2'b00, 0, 5'd0, 5'd6, 0, 0, 1, "adv6");
    vec(0, 1, 1, 0, 1, 2'b00, 1, 5'd1, 5'd1, 0, 0, 1, "ld1");
    vec(0, 1, 1, 0, 1, 2'b00, 0, 5'd0, 5'd0, 0, 0, 1, "dn0");
    vec(0, 1, 1, 0, 1, 2'b00, 0, 5'd0, 5'd15, 1, 0, 1, "dn_wrap");
    vec(0, 1, 1, 0, 1, 2'b00, 0, 5'd0, 5'd14, 0, 0, 1, "dn14");
    vec(0, 1, 1, 0, 0, 2'b11, 1, 5'd14, 5'd14, 0, 0, 1, "m3_ld14");
    vec(0, 1, 1, 0, 0, 2'b11, 0, 5'd0, 5'd15, 0, 0, 1, "m3_15");
    vec(0, 1, 1, 0, 0, 2'b11, 0, 5'd0, 5'd0, 1, 0, 1, "m3_wrap");
    vec(0, 1, 1, 0, 0, 2'b00, 0, 5'd0, 5'd1, 0, 0, 1, "pre_rst");
    vec(0, 0, 1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 0, 0, "rst_mid");

`ifdef FSM_SEQ_DWELL_EN
    // Dwell of 2 on N=4: three cycles per state, wrap at cycle 12
    dwell = 4'd2;
    vec(2, 0, 1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 0, 0, "rst_d");
    for (int k = 1; k <= 12; k++)
      vec(2, 1, 1, 0, 0, 2'b00, 0, 5'd0, 5'((k / 3) % 4), (k == 12), 0, 1, "dwell");
`endif

    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
